// File: rtl/flush_redirect_ctrl.sv
// flush_redirect_ctrl
//   Pipeline recovery sequencer. On a WB-stage exception or ERET commit it
//   flushes every stage in the commit cycle, then waits until all inst_sram
//   requests still in flight have returned. Those responses are marked stale
//   so that IF drops them. Finally it offers the new fetch PC to pre-IF over a
//   valid/ready handshake. An outstanding-request counter also throttles
//   pre-IF in normal operation.

module flush_redirect_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hbfc00380,
  parameter int          MAX_OUTST  = 4,
  parameter int          CNT_W      = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ws_exc,
  input  logic        ws_eret,
  input  logic [31:0] cp0_epc,
  input  logic        inst_req_fire,
  input  logic        inst_data_ok,
  output logic        req_allow,
  output logic        fetch_hold,
  output logic        discard_rdata,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        ctrl_busy
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CANCEL   = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTST);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  // The exception vector takes priority when an exception and an ERET
  // commit in the same cycle.
  function automatic logic [31:0] pick_target(input logic        exc,
                                               input logic [31:0] epc);
    logic [31:0] tgt;
    if (exc) begin
      tgt = EXC_VECTOR;
    end else begin
      tgt = epc;
    end
    return tgt;
  endfunction

  state_t           state;
  logic [CNT_W-1:0] outst;
  logic [CNT_W-1:0] outst_next;
  logic             event_s;
  logic             fire_eff;
  logic             dec_eff;
  logic [31:0]      target;

  assign event_s = ws_exc | ws_eret;
  assign target  = pick_target(ws_exc, cp0_epc);

  // Only IDLE may accept new requests. A fire while pre-IF is held is a
  // protocol error, so it is not counted.
  assign fire_eff = inst_req_fire & (state == ST_IDLE);

  // A response with nothing outstanding and no same-cycle fire is a protocol
  // error. It must not underflow the counter.
  assign dec_eff  = inst_data_ok & ((outst != CNT_ZERO) | fire_eff);

  // Next outstanding count. It saturates at MAX_OUTST and stays put when a
  // fire and a response land together.
  always_comb begin
    outst_next = outst;
    case ({fire_eff, dec_eff})
      2'b10: begin
        if (outst < MAX_CNT) begin
          outst_next = outst + CNT_ONE;
        end else begin
          outst_next = outst;
        end
      end
      2'b01:   outst_next = outst - CNT_ONE;
      default: outst_next = outst;
    endcase
  end

  // Decode the handshake and flush outputs from state and the current inputs.
  // The flush must reach the stages in the same cycle as the WB commit.
  always_comb begin
    flush         = 1'b0;
    fetch_hold    = 1'b1;
    discard_rdata = 1'b0;
    case (state)
      ST_IDLE: begin
        flush         = event_s;
        fetch_hold    = event_s;
        discard_rdata = 1'b0;
      end
      ST_CANCEL: begin
        flush         = 1'b0;
        fetch_hold    = 1'b1;
        discard_rdata = inst_data_ok;
      end
      ST_REDIRECT: begin
        flush         = 1'b0;
        fetch_hold    = 1'b1;
        discard_rdata = 1'b0;
      end
      default: begin
        flush         = 1'b0;
        fetch_hold    = 1'b1;
        discard_rdata = 1'b0;
      end
    endcase
  end

  assign req_allow = !fetch_hold & (outst < MAX_CNT);

  // Outstanding inst_sram request counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      outst <= CNT_ZERO;
    end else begin
      outst <= outst_next;
    end
  end

  // Recovery FSM with registered redirect handshake, target PC and busy flag.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= ST_IDLE;
      redirect_pc    <= 32'h0000_0000;
      redirect_valid <= 1'b0;
      ctrl_busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (event_s) begin
            redirect_pc <= target;
            ctrl_busy   <= 1'b1;
            if (outst_next == CNT_ZERO) begin
              state          <= ST_REDIRECT;
              redirect_valid <= 1'b1;
            end else begin
              state          <= ST_CANCEL;
              redirect_valid <= 1'b0;
            end
          end else begin
            state          <= ST_IDLE;
            redirect_valid <= 1'b0;
            ctrl_busy      <= 1'b0;
          end
        end
        ST_CANCEL: begin
          // Events here are ignored. The pipeline has already been flushed.
          ctrl_busy <= 1'b1;
          if (outst_next == CNT_ZERO) begin
            state          <= ST_REDIRECT;
            redirect_valid <= 1'b1;
          end else begin
            state          <= ST_CANCEL;
            redirect_valid <= 1'b0;
          end
        end
        ST_REDIRECT: begin
          // Hold valid and PC steady until pre-IF takes the redirect.
          if (redirect_ready) begin
            state          <= ST_IDLE;
            redirect_valid <= 1'b0;
            ctrl_busy      <= 1'b0;
          end else begin
            state          <= ST_REDIRECT;
            redirect_valid <= 1'b1;
            ctrl_busy      <= 1'b1;
          end
        end
        default: begin
          state          <= ST_IDLE;
          redirect_valid <= 1'b0;
          ctrl_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flush_redirect_ctrl.sv
// Directed self-checking bench for flush_redirect_ctrl.
module tb_flush_redirect_ctrl;

  logic        clk;
  logic        resetn;
  logic        ws_exc;
  logic        ws_eret;
  logic [31:0] cp0_epc;
  logic        inst_req_fire;
  logic        inst_data_ok;
  logic        req_allow;
  logic        fetch_hold;
  logic        discard_rdata;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
  logic        ctrl_busy;

  int n_pass;
  int n_total;

  localparam logic [31:0] EXC_PC = 32'hbfc00380;
  localparam logic [31:0] EPC_A  = 32'h8000_1234;

  flush_redirect_ctrl dut (
    .clk            (clk),
    .resetn         (resetn),
    .ws_exc         (ws_exc),
    .ws_eret        (ws_eret),
    .cp0_epc        (cp0_epc),
    .inst_req_fire  (inst_req_fire),
    .inst_data_ok   (inst_data_ok),
    .req_allow      (req_allow),
    .fetch_hold     (fetch_hold),
    .discard_rdata  (discard_rdata),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready),
    .ctrl_busy      (ctrl_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    resetn = 1'b0;
    ws_exc = 1'b0;
    ws_eret = 1'b0;
    cp0_epc = 32'h0;
    inst_req_fire = 1'b0;
    inst_data_ok = 1'b0;
    redirect_ready = 1'b0;

    // 1 reset held for 3 cycles
    tick(); tick(); tick();
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_rvalid", {31'd0, redirect_valid}, 32'd0);
    chk("rst_rpc", redirect_pc, 32'h0);
    chk("rst_req_allow", {31'd0, req_allow}, 32'd1);
    chk("rst_busy", {31'd0, ctrl_busy}, 32'd0);
    chk("rst_hold", {31'd0, fetch_hold}, 32'd0);
    resetn = 1'b1;
    tick();

    // 2 exception with nothing outstanding
    ws_exc = 1'b1;
    #1;
    chk("t2_flush", {31'd0, flush}, 32'd1);
    chk("t2_hold", {31'd0, fetch_hold}, 32'd1);
    chk("t2_req_allow", {31'd0, req_allow}, 32'd0);
    tick();
    ws_exc = 1'b0;
    #1;
    chk("t2_rvalid", {31'd0, redirect_valid}, 32'd1);
    chk("t2_rpc", redirect_pc, EXC_PC);
    chk("t2_flush_off", {31'd0, flush}, 32'd0);
    chk("t2_busy", {31'd0, ctrl_busy}, 32'd1);
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    chk("t2_rvalid_drop", {31'd0, redirect_valid}, 32'd0);
    chk("t2_idle", {31'd0, ctrl_busy}, 32'd0);

    // 3 ERET with two requests in flight
    inst_req_fire = 1'b1;
    tick(); tick();
    inst_req_fire = 1'b0;
    ws_eret = 1'b1;
    cp0_epc = EPC_A;
    #1;
    chk("t3_flush", {31'd0, flush}, 32'd1);
    tick();
    ws_eret = 1'b0;
    cp0_epc = 32'h1111_2222;
    chk("t3_cancel_busy", {31'd0, ctrl_busy}, 32'd1);
    chk("t3_cancel_rvalid", {31'd0, redirect_valid}, 32'd0);
    chk("t3_cancel_flush", {31'd0, flush}, 32'd0);
    chk("t3_discard_idle", {31'd0, discard_rdata}, 32'd0);
    inst_data_ok = 1'b1;
    #1;
    chk("t3_discard1", {31'd0, discard_rdata}, 32'd1);
    tick();
    chk("t3_rvalid_mid", {31'd0, redirect_valid}, 32'd0);
    chk("t3_discard2", {31'd0, discard_rdata}, 32'd1);
    tick();
    inst_data_ok = 1'b0;
    chk("t3_rvalid", {31'd0, redirect_valid}, 32'd1);
    chk("t3_rpc", redirect_pc, EPC_A);
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    chk("t3_done", {31'd0, redirect_valid}, 32'd0);

    // 4 exc+eret together, one outstanding that returns in the same cycle
    inst_req_fire = 1'b1;
    tick();
    inst_req_fire = 1'b0;
    ws_exc = 1'b1;
    ws_eret = 1'b1;
    cp0_epc = EPC_A;
    inst_data_ok = 1'b1;
    #1;
    chk("t4_flush", {31'd0, flush}, 32'd1);
    chk("t4_no_discard", {31'd0, discard_rdata}, 32'd0);
    tick();
    ws_exc = 1'b0;
    ws_eret = 1'b0;
    inst_data_ok = 1'b0;
    chk("t4_rvalid", {31'd0, redirect_valid}, 32'd1);
    chk("t4_rpc", redirect_pc, EXC_PC);
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;

    // 5 saturate at four outstanding requests
    inst_req_fire = 1'b1;
    tick(); tick(); tick();
    chk("t5_allow_at3", {31'd0, req_allow}, 32'd1);
    tick();
    inst_req_fire = 1'b0;
    chk("t5_allow_at4", {31'd0, req_allow}, 32'd0);
    inst_data_ok = 1'b1;
    tick();
    inst_data_ok = 1'b0;
    chk("t5_allow_after_ok", {31'd0, req_allow}, 32'd1);
    inst_data_ok = 1'b1;
    tick(); tick(); tick();
    // One extra response with nothing outstanding must not underflow.
    tick();
    inst_data_ok = 1'b0;

    // 6a redirect held without ready; later events ignored
    ws_exc = 1'b1;
    tick();
    ws_exc = 1'b0;
    chk("t6_rvalid_first", {31'd0, redirect_valid}, 32'd1);
    ws_eret = 1'b1;
    cp0_epc = 32'h9000_0000;
    for (int i = 0; i < 5; i++) begin
      chk("t6_hold_flush", {31'd0, flush}, 32'd0);
      tick();
      chk("t6_hold_rvalid", {31'd0, redirect_valid}, 32'd1);
      chk("t6_hold_rpc", redirect_pc, EXC_PC);
    end
    ws_eret = 1'b0;
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    chk("t6_released", {31'd0, redirect_valid}, 32'd0);

    // 6b reset while cancelling
    inst_req_fire = 1'b1;
    tick(); tick();
    inst_req_fire = 1'b0;
    ws_exc = 1'b1;
    tick();
    ws_exc = 1'b0;
    chk("t6_cancel_busy", {31'd0, ctrl_busy}, 32'd1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("t6_rst_busy", {31'd0, ctrl_busy}, 32'd0);
    chk("t6_rst_rvalid", {31'd0, redirect_valid}, 32'd0);
    chk("t6_rst_rpc", redirect_pc, 32'h0);
    chk("t6_rst_allow", {31'd0, req_allow}, 32'd1);
    tick(); tick();
    chk("t6_no_redirect", {31'd0, redirect_valid}, 32'd0);
    // The counter must restart from zero, so the fourth fire is the one that blocks.
    inst_req_fire = 1'b1;
    tick(); tick(); tick();
    chk("t6_cnt_at3", {31'd0, req_allow}, 32'd1);
    tick();
    inst_req_fire = 1'b0;
    chk("t6_cnt_at4", {31'd0, req_allow}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
